// File: rtl/bus_sequencer_if.sv
// bus_sequencer_if: sequencer bus bundle (start/step_mode/opcode/zero in; memory controls, datapath strobes, halt/phase/instr_cnt out)
interface bus_sequencer_if #(
  parameter int OPCODE_WIDTH = 3,
  parameter int PHASE_WIDTH = 3,
  parameter int CNT_WIDTH = 16
) ();
  logic start;
  logic step_mode;
  logic [OPCODE_WIDTH-1:0] opcode;
  logic zero;
  logic sel;
  logic rd;
  logic ld_ir;
  logic wr;
  logic data_e;
  logic inc_pc;
  logic ld_pc;
  logic ld_ac;
  logic halt;
  logic [PHASE_WIDTH-1:0] phase;
  logic [CNT_WIDTH-1:0] instr_cnt;
  modport master (
    input start, step_mode, opcode, zero,
    output sel, rd, ld_ir, wr, data_e, inc_pc, ld_pc, ld_ac, halt, phase, instr_cnt
  );
  modport slave (
    output start, step_mode, opcode, zero,
    input sel, rd, ld_ir, wr, data_e, inc_pc, ld_pc, ld_ac, halt, phase, instr_cnt
  );
endinterface

// File: rtl/bus_sequencer.sv
// bus_sequencer: 8-phase instruction sequencer with run/stop/halt, single-step and saturating retired count (clk, rst, bus master modport)
module bus_sequencer #(
  parameter int OPCODE_WIDTH = 3,
  parameter int PHASE_WIDTH = 3,
  parameter int CNT_WIDTH = 16
) (
  input logic clk,
  input logic rst,
  bus_sequencer_if.master bus
);
  localparam logic [1:0] STOPPED = 2'd0;
  localparam logic [1:0] RUN = 2'd1;
  localparam logic [1:0] HALTED = 2'd2;
  localparam logic [OPCODE_WIDTH-1:0] HLT = OPCODE_WIDTH'(0);
  localparam logic [OPCODE_WIDTH-1:0] SKZ = OPCODE_WIDTH'(1);
  localparam logic [OPCODE_WIDTH-1:0] ADD = OPCODE_WIDTH'(2);
  localparam logic [OPCODE_WIDTH-1:0] AND = OPCODE_WIDTH'(3);
  localparam logic [OPCODE_WIDTH-1:0] XOR = OPCODE_WIDTH'(4);
  localparam logic [OPCODE_WIDTH-1:0] LDA = OPCODE_WIDTH'(5);
  localparam logic [OPCODE_WIDTH-1:0] STO = OPCODE_WIDTH'(6);
  localparam logic [OPCODE_WIDTH-1:0] JMP = OPCODE_WIDTH'(7);
  logic [1:0] state;
  logic [PHASE_WIDTH-1:0] p;
  logic [CNT_WIDTH-1:0] cnt;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic run, aluop, hlt, sto, jmp, skz;
  always_comb begin
    run = state == RUN;
    aluop = bus.opcode inside {ADD, AND, XOR, LDA};
    hlt = bus.opcode == HLT;
    sto = bus.opcode == STO;
    jmp = bus.opcode == JMP;
    skz = bus.opcode == SKZ;
    cnt_inc = &cnt ? cnt : cnt + 1'b1;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= STOPPED;
      p <= '0;
      cnt <= '0;
    end else if (!run) begin
      if (bus.start) begin
        state <= RUN;
        p <= '0;
      end
    end else if (p == 4 && hlt) begin
      state <= HALTED;
      p <= '0;
      cnt <= cnt_inc;
    end else if (p == 7) begin
      p <= '0;
      cnt <= cnt_inc;
      state <= bus.step_mode ? STOPPED : RUN;
    end else begin
      p <= p + 1'b1;
    end
  end
  assign bus.sel = run && p < 4;
  assign bus.rd = run && (p inside {1, 2, 3} || (p >= 5 && aluop));
  assign bus.ld_ir = run && (p == 2 || p == 3);
  assign bus.wr = run && p == 7 && sto;
  assign bus.data_e = run && p >= 6 && sto;
  assign bus.inc_pc = run && (p == 4 || (p == 6 && skz && bus.zero));
  assign bus.ld_pc = run && p >= 6 && jmp;
  assign bus.ld_ac = run && p == 7 && aluop;
  assign bus.halt = state == HALTED || (run && p == 4 && hlt);
  assign bus.phase = p;
  assign bus.instr_cnt = cnt;
endmodule

// File: tb/tb_bus_sequencer.sv
// tb_bus_sequencer: randomized and directed check of bus_sequencer against a phase-table reference model
module tb_bus_sequencer;
  logic clk = 0;
  logic rst = 1;
  logic start = 0;
  logic step_mode = 0;
  logic zero = 0;
  logic [2:0] opcode = 0;
  int vectors = 0;
  int miscompares = 0;
  int mmode = 0;
  int mph = 0;
  int mcnt = 0;
  always #5 clk = ~clk;
  bus_sequencer_if bus ();
  bus_sequencer_if #(.CNT_WIDTH(2)) bus2 ();
  assign bus.start = start;
  assign bus.step_mode = step_mode;
  assign bus.opcode = opcode;
  assign bus.zero = zero;
  assign bus2.start = start;
  assign bus2.step_mode = step_mode;
  assign bus2.opcode = opcode;
  assign bus2.zero = zero;
  bus_sequencer dut (.clk(clk), .rst(rst), .bus(bus.master));
  bus_sequencer #(.CNT_WIDTH(2)) dut_small (.clk(clk), .rst(rst), .bus(bus2.master));
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t phase=%0d op=%0d)", tag, got, exp, $time, mph, opcode);
    end
  endtask
  function automatic logic [8:0] exp_ctl(int mode, int ph, int op, bit z);
    bit alu = op inside {2, 3, 4, 5};
    bit sel_e = 0, rd_e = 0, ldir_e = 0, wr_e = 0, de_e = 0, inc_e = 0, ldpc_e = 0, ldac_e = 0, halt_e = 0;
    if (mode == 2) halt_e = 1;
    if (mode == 1) begin
      case (ph)
        0: sel_e = 1;
        1: begin sel_e = 1; rd_e = 1; end
        2, 3: begin sel_e = 1; rd_e = 1; ldir_e = 1; end
        4: begin inc_e = 1; halt_e = op == 0; end
        5: rd_e = alu;
        6: begin rd_e = alu; inc_e = op == 1 && z; ldpc_e = op == 7; de_e = op == 6; end
        default: begin rd_e = alu; ldac_e = alu; ldpc_e = op == 7; wr_e = op == 6; de_e = op == 6; end
      endcase
    end
    return {sel_e, rd_e, ldir_e, wr_e, de_e, inc_e, ldpc_e, ldac_e, halt_e};
  endfunction
  function automatic logic [8:0] ctl_of1();
    return {bus.sel, bus.rd, bus.ld_ir, bus.wr, bus.data_e, bus.inc_pc, bus.ld_pc, bus.ld_ac, bus.halt};
  endfunction
  function automatic logic [8:0] ctl_of2();
    return {bus2.sel, bus2.rd, bus2.ld_ir, bus2.wr, bus2.data_e, bus2.inc_pc, bus2.ld_pc, bus2.ld_ac, bus2.halt};
  endfunction
  task automatic check_all();
    logic [8:0] e;
    e = exp_ctl(mmode, mph, int'(opcode), zero);
    chk("ctl", 32'(ctl_of1()), 32'(e));
    chk("ctl_small", 32'(ctl_of2()), 32'(e));
    chk("phase", 32'(bus.phase), 32'(mph));
    chk("instr_cnt", 32'(bus.instr_cnt), 32'(mcnt));
    chk("instr_cnt_sat", 32'(bus2.instr_cnt), 32'(mcnt > 3 ? 3 : mcnt));
    chk("rd_and_wr", 32'(bus.rd & bus.wr), 0);
    chk("wr_without_data_e", 32'(bus.wr & ~bus.data_e), 0);
  endtask
  task automatic cyc();
    @(negedge clk);
    #1;
    check_all();
    @(posedge clk);
    #1;
    if (rst) begin
      mmode = 0; mph = 0; mcnt = 0;
    end else if (mmode != 1) begin
      if (start) begin mmode = 1; mph = 0; end
    end else if (mph == 4 && opcode == 0) begin
      mmode = 2; mph = 0; mcnt = mcnt + 1 > 65535 ? 65535 : mcnt + 1;
    end else if (mph == 7) begin
      mph = 0; mcnt = mcnt + 1 > 65535 ? 65535 : mcnt + 1;
      if (step_mode) mmode = 0;
    end else begin
      mph++;
    end
  endtask
  task automatic run_n(input int n);
    for (int i = 0; i < n; i++) cyc();
  endtask
  task automatic pulse_start();
    start = 1;
    cyc();
    start = 0;
  endtask
  task automatic instr(input int op, input bit z);
    opcode = 3'(op);
    zero = z;
    run_n(8);
  endtask
  initial begin
    #1;
    check_all();
    run_n(2);
    rst = 0;
    run_n(2);
    opcode = 5;
    pulse_start();
    instr(5, 0);
    instr(6, 0);
    instr(1, 1);
    instr(1, 0);
    opcode = 0;
    run_n(5);
    run_n(3);
    pulse_start();
    step_mode = 1;
    opcode = 7;
    run_n(7);
    start = 1;
    cyc();
    start = 0;
    run_n(10);
    pulse_start();
    instr(4, 1);
    run_n(3);
    step_mode = 0;
    opcode = 2;
    pulse_start();
    run_n(5);
    #2 rst = 1;
    #1;
    chk("rst_ctl", 32'(ctl_of1()), 0);
    chk("rst_phase", 32'(bus.phase), 0);
    chk("rst_cnt", 32'(bus.instr_cnt), 0);
    mmode = 0; mph = 0; mcnt = 0;
    run_n(2);
    rst = 0;
    for (int i = 0; i < 600; i++) begin
      if (mmode != 1 || mph == 0) opcode = 3'($urandom_range(0, 7));
      zero = 1'($urandom_range(0, 1));
      step_mode = $urandom_range(0, 3) == 0;
      start = $urandom_range(0, 5) == 0;
      cyc();
    end
    start = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
